fx2_in_streamer: RTL and testbench
==================================

Name: fx2_in_streamer

Overview:
- FPGA-to-host transmitter for the FX2 slave-FIFO interface; the write-side counterpart of the FIFO2 reader.
- Accepts a local byte stream over valid/ready and writes it into the FX2 IN endpoint FIFO4 using FIFO_WR.
- Full packets auto-commit in the FX2. The block commits short packets with FIFO_PKTEND on idle timeout or on an explicit flush.
- Shares the bidirectional FD bus with the OUT-side reader through a req/gnt handshake with a turnaround cycle.

Parameters:
- PKT_SIZE, 512: FX2 endpoint packet size in bytes (power of 2, 64..1024).
- TIMEOUT, 255: idle cycles in WRITE before a partial packet is committed (1..65535).
- FIFOADR_IN, 2'b10: FIFOADR value selecting FIFO4.

Ports:
- FX2_CLK  in  1  FX2 interface clock; the only clock.
- FX2_RST  in  1  asynchronous, active-high reset.
- src_data  in  8  stream byte.
- src_valid  in  1  src_data valid.
- src_ready  out  1  byte accepted when src_valid & src_ready.
- flush  in  1  single-cycle request to commit the current partial packet.
- flush_done  out  1  one-cycle pulse when the flush is serviced.
- bus_req  out  1  request ownership of the FD bus.
- bus_gnt  in  1  ownership granted; deassertion asks the block to release.
- FIFO4_ready_to_accept_data  in  1  positive-logic not-full flag.
- FIFO_WR  out  1  write strobe, positive logic.
- FIFO_PKTEND  out  1  packet-end strobe, positive logic.
- FIFO_DATAOUT  out  8  data driven onto FD.
- FIFO_DATAOUT_OE  out  1  FD output enable.
- FIFO_FIFOADR  out  2  endpoint select.
- bytes_sent  out  32  total bytes written since reset; wraps.

Behaviour:
- Reset (async, immediate): state IDLE. All strobes, OE, bus_req, src_ready and flush_done are 0. FIFO_FIFOADR=0, FIFO_DATAOUT=0, pkt_cnt=0, idle_cnt=0, bytes_sent=0, pending flush cleared. Reset mid-write: OE drops in the same instant; the partial packet is abandoned with no PKTEND.
- States: IDLE, TURN, WRITE, COMMIT, RELEASE.
- IDLE:
  - bus_req=1 when src_valid, a pending flush, or pkt_cnt!=0.
  - Go to TURN when bus_req & bus_gnt.
- TURN:
  - One cycle. FIFOADR=FIFOADR_IN, OE=1, no strobes.
  - Then go to WRITE.
- WRITE:
  - FIFOADR=FIFOADR_IN, OE=1, bus_req=1.
  - src_ready = FIFO_WR = src_valid & FIFO4_ready_to_accept_data (src_ready depends on src_valid).
  - FIFO_DATAOUT = src_data, combinational pass-through.
  - Each write: pkt_cnt+1, wrapping to 0 at PKT_SIZE (FX2 auto-commit); bytes_sent+1; idle_cnt cleared.
  - Cycle with no write: idle_cnt+1, saturating.
  - Exit priority, evaluated each cycle:
    1. Pending flush or idle_cnt==TIMEOUT with pkt_cnt!=0 → COMMIT. No write occurs in this cycle.
    2. Pending flush with pkt_cnt==0 → flush_done pulse, flush cleared, stay in WRITE.
    3. bus_gnt=0 and pkt_cnt==0 → RELEASE.
  - With bus_gnt=0 and pkt_cnt!=0, the block keeps writing until the packet completes or times out.
- COMMIT:
  - FIFO_PKTEND=1 for exactly one cycle, only when FIFO4_ready_to_accept_data; otherwise wait. Never asserted together with FIFO_WR.
  - On PKTEND: pkt_cnt=0, idle_cnt=0. If the commit came from a flush, pulse flush_done and clear the flush.
  - Next state: RELEASE if bus_gnt=0, else WRITE.
- RELEASE:
  - One cycle with OE=0, bus_req=0, FIFOADR=0, no strobes.
  - Then go to IDLE.
- flush:
  - Latched into a pending bit in any state.
  - A flush arriving while one is pending merges into it (one flush_done).
- FIFO full: writes stall and idle_cnt counts. Timeout with pkt_cnt!=0 waits in COMMIT for not-full.
- PKT_SIZE boundary: the byte that makes pkt_cnt wrap to 0 never triggers PKTEND.

Optional Feature:
- Macro FX2_IN_ZLP_EN.
- Defined: a flush with pkt_cnt==0 goes to COMMIT and issues PKTEND, sending a zero-length packet so the host read terminates. A flush right after an auto-committed full packet therefore yields a ZLP.
- Undefined: a flush with pkt_cnt==0 only pulses flush_done; no PKTEND.

Test Plan:
- gnt held 1, 3 bytes 0xA1,0xA2,0xA3 streamed, FIFO ready → bus_req, one TURN cycle with OE=1 and no WR, three WR cycles carrying A1..A3. After 255 idle cycles, one PKTEND cycle; bytes_sent=3.
- 512 consecutive bytes, PKT_SIZE=512 → 512 WR pulses, no PKTEND, pkt_cnt=0 afterwards, bytes_sent=512.
- FIFO4_ready low for 10 cycles mid-stream → src_ready=0 and no WR for those 10 cycles; no data lost or duplicated; byte order preserved.
- 5 bytes, then flush → PKTEND within ≤2 cycles after the last write, flush_done one cycle; flush at pkt_cnt==0 → flush_done only, or a PKTEND with FX2_IN_ZLP_EN.
- bus_gnt dropped at pkt_cnt=7 → writes continue; on timeout PKTEND, then RELEASE with OE=0 for one cycle, then IDLE with bus_req=0.
- FX2_RST pulsed during WRITE at pkt_cnt=4 → OE, WR and bus_req are 0 immediately; after release the next packet starts from pkt_cnt=0 and bytes_sent=0.

Source files
------------

// File: rtl/fx2_in_streamer.sv
// Streams local bytes into the FX2 IN endpoint (FIFO4) and commits short packets with PKTEND.
// Define FX2_IN_ZLP_EN so that a flush with no buffered bytes sends a zero-length packet.
module fx2_in_streamer #(
    parameter int         PKT_SIZE   = 512,
    parameter int         TIMEOUT    = 255,
    parameter logic [1:0] FIFOADR_IN = 2'b10
) (
    input  logic        FX2_CLK,
    input  logic        FX2_RST,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic        flush,
    output logic        flush_done,
    output logic        bus_req,
    input  logic        bus_gnt,
    input  logic        FIFO4_ready_to_accept_data,
    output logic        FIFO_WR,
    output logic        FIFO_PKTEND,
    output logic [7:0]  FIFO_DATAOUT,
    output logic        FIFO_DATAOUT_OE,
    output logic [1:0]  FIFO_FIFOADR,
    output logic [31:0] bytes_sent
);
    localparam int          PW        = $clog2(PKT_SIZE);
    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, TURN, WRITE, COMMIT, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [15:0]     idle_cnt_q, idle_cnt_d;
    logic [31:0]     bytes_q, bytes_d;
    logic            flush_pend_q, flush_pend_d;
    logic            flush_done_q, flush_done_d;
    logic            oe_q, oe_d;
    logic [1:0]      fifoadr_q, fifoadr_d;
    logic            do_wr, do_pktend, service_flush;
    logic            pkt_nz, timed_out, bus_req_w;

    assign pkt_nz    = (pkt_cnt_q != '0);
    assign timed_out = (idle_cnt_q == TIMEOUT_V);

    always_comb begin
        case (state_q)
            IDLE:                 bus_req_w = src_valid | flush_pend_q | pkt_nz;
            TURN, WRITE, COMMIT:  bus_req_w = 1'b1;
            default:              bus_req_w = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pkt_cnt_d     = pkt_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        bytes_d       = bytes_q;
        do_wr         = 1'b0;
        do_pktend     = 1'b0;
        service_flush = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_req_w && bus_gnt) state_d = TURN;
            end
            TURN: begin
                idle_cnt_d = '0;
                state_d    = WRITE;
            end
            WRITE: begin
`ifdef FX2_IN_ZLP_EN
                if (flush_pend_q || (timed_out && pkt_nz)) begin
`else
                if ((flush_pend_q || timed_out) && pkt_nz) begin
`endif
                    state_d = COMMIT;
                end else begin
                    if (flush_pend_q)
                        service_flush = 1'b1;
                    else if (!bus_gnt && !pkt_nz)
                        state_d = RELEASE;
                    // never write on the way out, or a byte would be stranded uncommitted
                    do_wr = src_valid && FIFO4_ready_to_accept_data && (state_d == WRITE);
                    if (do_wr) begin
                        pkt_cnt_d  = pkt_cnt_q + PW'(1);
                        bytes_d    = bytes_q + 32'd1;
                        idle_cnt_d = '0;
                    end else if (!timed_out) begin
                        idle_cnt_d = idle_cnt_q + 16'd1;
                    end
                end
            end
            COMMIT: begin
                if (FIFO4_ready_to_accept_data) begin
                    do_pktend     = 1'b1;
                    pkt_cnt_d     = '0;
                    idle_cnt_d    = '0;
                    service_flush = flush_pend_q;
                    state_d       = bus_gnt ? WRITE : RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a flush landing in the servicing cycle merges into the one being serviced
        flush_pend_d = service_flush ? 1'b0 : (flush_pend_q | flush);
        flush_done_d = service_flush;
        oe_d         = (state_d == TURN) || (state_d == WRITE) || (state_d == COMMIT);
        fifoadr_d    = oe_d ? FIFOADR_IN : 2'b00;
    end

    always_ff @(posedge FX2_CLK or posedge FX2_RST) begin
        if (FX2_RST) begin
            state_q      <= IDLE;
            pkt_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            bytes_q      <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            oe_q         <= 1'b0;
            fifoadr_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            pkt_cnt_q    <= pkt_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            bytes_q      <= bytes_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            oe_q         <= oe_d;
            fifoadr_q    <= fifoadr_d;
        end
    end

    assign bus_req         = bus_req_w & ~FX2_RST;
    assign src_ready       = do_wr;
    assign FIFO_WR         = do_wr;
    assign FIFO_PKTEND     = do_pktend;
    assign FIFO_DATAOUT    = (state_q == WRITE) ? src_data : 8'h00;
    assign FIFO_DATAOUT_OE = oe_q;
    assign FIFO_FIFOADR    = fifoadr_q;
    assign bytes_sent      = bytes_q;
    assign flush_done      = flush_done_q;

endmodule

// File: tb/tb_fx2_in_streamer.sv
// Directed bench for fx2_in_streamer with default parameters (PKT_SIZE 512, TIMEOUT 255).
module tb_fx2_in_streamer;
    logic        clk = 1'b0;
    logic        FX2_RST;
    logic [7:0]  src_data;
    logic        src_valid, src_ready, flush, flush_done, bus_req, bus_gnt;
    logic        FIFO4_ready_to_accept_data, FIFO_WR, FIFO_PKTEND, FIFO_DATAOUT_OE;
    logic [7:0]  FIFO_DATAOUT;
    logic [1:0]  FIFO_FIFOADR;
    logic [31:0] bytes_sent;

    int nchk = 0, nerr = 0;
    int cyc = 0, last_wr_cyc = 0, pktend_cyc = 0;
    int pktend_cnt = 0, fd_cnt = 0, both_cnt = 0;
    logic [7:0] wr_q[$];
    int push_sent, stall_viol, stall_seen;

    fx2_in_streamer dut (
        .FX2_CLK(clk), .FX2_RST(FX2_RST), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .flush(flush), .flush_done(flush_done), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .FIFO4_ready_to_accept_data(FIFO4_ready_to_accept_data),
        .FIFO_WR(FIFO_WR), .FIFO_PKTEND(FIFO_PKTEND), .FIFO_DATAOUT(FIFO_DATAOUT),
        .FIFO_DATAOUT_OE(FIFO_DATAOUT_OE), .FIFO_FIFOADR(FIFO_FIFOADR), .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (FIFO_WR) begin wr_q.push_back(FIFO_DATAOUT); last_wr_cyc = cyc; end
        if (FIFO_PKTEND) begin pktend_cnt++; pktend_cyc = cyc; end
        if (FIFO_WR && FIFO_PKTEND) both_cnt++;
        if (flush_done) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Streams n bytes base, base+1, ...; optionally holds FIFO full for stall_len cycles after stall_after accepts.
    task automatic push(input int n, input logic [7:0] base, input int stall_after, input int stall_len);
        int guard = 0, left = 0;
        bit started = 0;
        push_sent = 0; stall_viol = 0; stall_seen = 0;
        src_valid = 1'b1;
        while (push_sent < n && guard < n + stall_len + 20) begin
            FIFO4_ready_to_accept_data = (left == 0);
            src_data = base + 8'(push_sent);
            @(negedge clk);
            if (left > 0) begin
                if (src_ready || FIFO_WR) stall_viol++;
                stall_seen++;
                left--;
            end
            if (src_ready) push_sent++;
            guard++;
            tick();
            if (!started && push_sent == stall_after) begin started = 1; left = stall_len; end
        end
        src_valid = 1'b0;
        FIFO4_ready_to_accept_data = 1'b1;
    endtask

    task automatic wait_pktend(input int budget, output bit seen);
        int start = pktend_cnt, g = 0;
        while (pktend_cnt == start && g < budget) begin tick(); g++; end
        seen = (pktend_cnt != start);
    endtask

    task automatic test_reset();
        FX2_RST = 1'b1; src_valid = 0; src_data = 0; flush = 0; bus_gnt = 0;
        FIFO4_ready_to_accept_data = 1'b1;
        tick(); tick();
        nchk++; if (FIFO_WR !== 1'b0) begin nerr++; $display("FAIL reset_wr: got %b want 0", FIFO_WR); end
        nchk++; if (FIFO_PKTEND !== 1'b0) begin nerr++; $display("FAIL reset_pktend: got %b want 0", FIFO_PKTEND); end
        nchk++; if (FIFO_DATAOUT_OE !== 1'b0) begin nerr++; $display("FAIL reset_oe: got %b want 0", FIFO_DATAOUT_OE); end
        nchk++; if (bus_req !== 1'b0) begin nerr++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        nchk++; if (src_ready !== 1'b0) begin nerr++; $display("FAIL reset_src_ready: got %b want 0", src_ready); end
        nchk++; if (flush_done !== 1'b0) begin nerr++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        nchk++; if (FIFO_FIFOADR !== 2'b00) begin nerr++; $display("FAIL reset_fifoadr: got %b want 00", FIFO_FIFOADR); end
        nchk++; if (FIFO_DATAOUT !== 8'h00) begin nerr++; $display("FAIL reset_dataout: got %h want 00", FIFO_DATAOUT); end
        nchk++; if (bytes_sent !== 32'd0) begin nerr++; $display("FAIL reset_bytes: got %0d want 0", bytes_sent); end
        FX2_RST = 1'b0;
        tick();
    endtask

    task automatic test_basic_timeout();
        int b = wr_q.size(), pe0, gap;
        bit seen;
        bus_gnt = 1'b1;
        src_valid = 1'b1; src_data = 8'hA1;
        @(negedge clk);
        nchk++; if (bus_req !== 1'b1) begin nerr++; $display("FAIL basic_bus_req: got %b want 1", bus_req); end
        tick(); @(negedge clk);
        nchk++; if ({FIFO_DATAOUT_OE, FIFO_WR, FIFO_FIFOADR} !== 4'b1010)
            begin nerr++; $display("FAIL basic_turn oe/wr/adr: got %b want 1010", {FIFO_DATAOUT_OE, FIFO_WR, FIFO_FIFOADR}); end
        tick();
        push(3, 8'hA1, -1, 0);
        nchk++; if (wr_q.size() - b != 3 || wr_q[b] !== 8'hA1 || wr_q[b+1] !== 8'hA2 || wr_q[b+2] !== 8'hA3)
            begin nerr++; $display("FAIL basic_data: got %0d writes want 3 (A1 A2 A3)", wr_q.size() - b); end
        pe0 = pktend_cnt;
        wait_pktend(400, seen);
        gap = pktend_cyc - last_wr_cyc;
        nchk++; if (!seen || gap < 256 || gap > 258)
            begin nerr++; $display("FAIL timeout_gap: got seen=%0d gap=%0d want gap 256..258", seen, gap); end
        repeat (5) tick();
        nchk++; if (pktend_cnt - pe0 != 1) begin nerr++; $display("FAIL timeout_once: got %0d pktend want 1", pktend_cnt - pe0); end
        nchk++; if (bytes_sent !== 32'd3) begin nerr++; $display("FAIL basic_bytes: got %0d want 3", bytes_sent); end
    endtask

    task automatic test_full_packet();
        int b = wr_q.size(), pe0 = pktend_cnt, bad = 0;
        push(512, 8'h00, -1, 0);
        for (int i = 0; i < 512; i++) if (b + i >= wr_q.size() || wr_q[b+i] !== 8'(i)) bad++;
        nchk++; if (wr_q.size() - b != 512 || bad != 0)
            begin nerr++; $display("FAIL full_data: got %0d writes %0d bad want 512 0", wr_q.size() - b, bad); end
        repeat (300) tick();
        nchk++; if (pktend_cnt != pe0) begin nerr++; $display("FAIL full_no_pktend: got %0d pktend want 0", pktend_cnt - pe0); end
        nchk++; if (bytes_sent !== 32'd515) begin nerr++; $display("FAIL full_bytes: got %0d want 515", bytes_sent); end
    endtask

    task automatic test_stall();
        int b = wr_q.size(), bad = 0;
        push(20, 8'h40, 6, 10);
        nchk++; if (stall_viol != 0 || stall_seen != 10)
            begin nerr++; $display("FAIL stall_hold: got viol=%0d cycles=%0d want 0 10", stall_viol, stall_seen); end
        for (int i = 0; i < 20; i++) if (b + i >= wr_q.size() || wr_q[b+i] !== 8'h40 + 8'(i)) bad++;
        nchk++; if (wr_q.size() - b != 20 || bad != 0)
            begin nerr++; $display("FAIL stall_data: got %0d writes %0d bad want 20 0", wr_q.size() - b, bad); end
        nchk++; if (bytes_sent !== 32'd535) begin nerr++; $display("FAIL stall_bytes: got %0d want 535", bytes_sent); end
    endtask

    task automatic test_flush();
        int pe0, fd0, gap, zlp_exp;
        bit seen;
        push(4, 8'h80, -1, 0);
        src_valid = 1'b1; src_data = 8'h84; flush = 1'b1;
        @(negedge clk);
        nchk++; if (FIFO_WR !== 1'b1) begin nerr++; $display("FAIL flush_last_wr: got %b want 1", FIFO_WR); end
        tick(); src_valid = 1'b0; flush = 1'b0;
        fd0 = fd_cnt;
        wait_pktend(10, seen);
        gap = pktend_cyc - last_wr_cyc;
        nchk++; if (!seen || gap > 2) begin nerr++; $display("FAIL flush_pktend: got seen=%0d gap=%0d want gap<=2", seen, gap); end
        repeat (4) tick();
        nchk++; if (fd_cnt - fd0 != 1) begin nerr++; $display("FAIL flush_done_once: got %0d want 1", fd_cnt - fd0); end
        nchk++; if (bytes_sent !== 32'd540) begin nerr++; $display("FAIL flush_bytes: got %0d want 540", bytes_sent); end
`ifdef FX2_IN_ZLP_EN
        zlp_exp = 1;
`else
        zlp_exp = 0;
`endif
        pe0 = pktend_cnt; fd0 = fd_cnt;
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (6) tick();
        nchk++; if (fd_cnt - fd0 != 1 || pktend_cnt - pe0 != zlp_exp)
            begin nerr++; $display("FAIL empty_flush: got done=%0d pktend=%0d want 1 %0d", fd_cnt - fd0, pktend_cnt - pe0, zlp_exp); end
        pe0 = pktend_cnt; fd0 = fd_cnt;
        flush = 1'b1; tick(); tick(); flush = 1'b0;
        repeat (6) tick();
        nchk++; if (fd_cnt - fd0 != 1 || pktend_cnt - pe0 != zlp_exp)
            begin nerr++; $display("FAIL merged_flush: got done=%0d pktend=%0d want 1 %0d", fd_cnt - fd0, pktend_cnt - pe0, zlp_exp); end
    endtask

    task automatic test_release();
        int b = wr_q.size();
        bit seen;
        push(7, 8'h10, -1, 0);
        bus_gnt = 1'b0;
        push(3, 8'h17, -1, 0);
        nchk++; if (wr_q.size() - b != 10 || push_sent != 3)
            begin nerr++; $display("FAIL release_keep_writing: got %0d writes want 10", wr_q.size() - b); end
        wait_pktend(400, seen);
        nchk++; if (!seen) begin nerr++; $display("FAIL release_timeout_pktend: got none want 1"); end
        @(negedge clk);
        nchk++; if ({FIFO_DATAOUT_OE, bus_req, FIFO_FIFOADR} !== 4'b0000)
            begin nerr++; $display("FAIL release_cycle oe/req/adr: got %b want 0000", {FIFO_DATAOUT_OE, bus_req, FIFO_FIFOADR}); end
        tick(); @(negedge clk);
        nchk++; if ({FIFO_DATAOUT_OE, bus_req} !== 2'b00)
            begin nerr++; $display("FAIL release_idle oe/req: got %b want 00", {FIFO_DATAOUT_OE, bus_req}); end
        nchk++; if (bytes_sent !== 32'd550) begin nerr++; $display("FAIL release_bytes: got %0d want 550", bytes_sent); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        bus_gnt = 1'b1;
        push(4, 8'h20, -1, 0);
        src_valid = 1'b1; src_data = 8'h24;
        @(negedge clk);
        nchk++; if (FIFO_WR !== 1'b1) begin nerr++; $display("FAIL pre_reset_wr: got %b want 1", FIFO_WR); end
        #1 FX2_RST = 1'b1;
        #1;
        nchk++; if ({FIFO_DATAOUT_OE, FIFO_WR, bus_req, src_ready, FIFO_PKTEND} !== 5'b00000)
            begin nerr++; $display("FAIL rst_mid oe/wr/req/rdy/pe: got %b want 00000", {FIFO_DATAOUT_OE, FIFO_WR, bus_req, src_ready, FIFO_PKTEND}); end
        nchk++; if (bytes_sent !== 32'd0) begin nerr++; $display("FAIL rst_mid_bytes: got %0d want 0", bytes_sent); end
        src_valid = 1'b0;
        tick(); FX2_RST = 1'b0; tick();
        push(508, 8'h00, -1, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_pktend(10, seen);
        nchk++; if (!seen) begin nerr++; $display("FAIL rst_pkt_restart: got no pktend want 1 (508 bytes pending)"); end
        nchk++; if (bytes_sent !== 32'd508) begin nerr++; $display("FAIL rst_bytes_after: got %0d want 508", bytes_sent); end
    endtask

    task automatic test_no_overlap();
        nchk++; if (both_cnt != 0) begin nerr++; $display("FAIL wr_pktend_overlap: got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_timeout();
        test_full_packet();
        test_stall();
        test_flush();
        test_release();
        test_reset_mid_write();
        test_no_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
